// File: rtl/gpu_bus_arbiter_pkg.sv
// Shared types and constants for the two-master GPU word-bus arbiter.
package gpu_bus_arbiter_pkg;

  localparam int unsigned GPU_BUS_AW = 20;
  localparam int unsigned GPU_BUS_DW = 32;
  localparam int unsigned GPU_BUS_BW = GPU_BUS_DW / 8;

  localparam logic MID_M0 = 1'b0;
  localparam logic MID_M1 = 1'b1;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/gpu_bus_arbiter_if.sv
// Bundle of both master command ports and the downstream word bus.
// slave = arbiter view; master = view of whatever drives the masters and bus.
interface gpu_bus_arbiter_if
  import gpu_bus_arbiter_pkg::*;
#(
  parameter int unsigned AW = GPU_BUS_AW
) ();

  logic                  m0_req,    m1_req;
  logic                  m0_lock,   m1_lock;
  logic [GPU_BUS_BW-1:0] m0_wen,    m1_wen;
  logic [AW-1:0]         m0_addr,   m1_addr;
  logic [GPU_BUS_DW-1:0] m0_wdata,  m1_wdata;
  logic                  m0_gnt,    m1_gnt;
  logic                  m0_rvalid, m1_rvalid;
  logic [GPU_BUS_DW-1:0] m0_rdata,  m1_rdata;

  logic                  bus_en;
  logic [GPU_BUS_BW-1:0] bus_wen;
  logic [AW-1:0]         bus_addr;
  logic [GPU_BUS_DW-1:0] bus_wdata;
  logic [GPU_BUS_DW-1:0] bus_rdata;

  modport slave (
    input  m0_req, m1_req, m0_lock, m1_lock, m0_wen, m1_wen,
           m0_addr, m1_addr, m0_wdata, m1_wdata, bus_rdata,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           bus_en, bus_wen, bus_addr, bus_wdata
  );

  modport master (
    output m0_req, m1_req, m0_lock, m1_lock, m0_wen, m1_wen,
           m0_addr, m1_addr, m0_wdata, m1_wdata, bus_rdata,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           bus_en, bus_wen, bus_addr, bus_wdata
  );

endinterface

// File: rtl/gpu_bus_arbiter_rr_pick.sv
// Two-way combinational round-robin picker: on a tie the master that did
// not win last time is selected.
module gpu_bus_arbiter_rr_pick (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       sel_o,
  output logic       any_o
);

  always_comb begin
    any_o = |req_i;
    sel_o = req_i[1];
    if (&req_i) sel_o = ~last_i;
  end

endmodule

// File: rtl/gpu_bus_arbiter.sv
// Round-robin arbiter with bus lock between the AXI bridge (m0) and the
// fill/blit engine (m1). Define GPU_ARB_WDOG_EN to enable the lock watchdog.
module gpu_bus_arbiter
  import gpu_bus_arbiter_pkg::*;
#(
  parameter int unsigned AW = GPU_BUS_AW
`ifdef GPU_ARB_WDOG_EN
  , parameter int unsigned LOCK_MAX = 256
`endif
) (
  input  logic              aclk,
  input  logic              areset,
  gpu_bus_arbiter_if.slave  bif,
  output logic              arb_owner,
  output logic              wdog_err
);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_id_q, rd_id_d;

  logic                  pick_sel, pick_any;
  logic                  win_c, en_c;
  logic                  win_req, win_lock;
  logic [GPU_BUS_BW-1:0] win_wen;
  logic [AW-1:0]         win_addr;
  logic [GPU_BUS_DW-1:0] win_wdata;

  gpu_bus_arbiter_rr_pick u_pick (
    .req_i  ({bif.m1_req, bif.m0_req}),
    .last_i (owner_q),
    .sel_o  (pick_sel),
    .any_o  (pick_any)
  );

  // While locked only the lock holder (the most recent winner) can be served.
  assign win_c = (state_q == ARB_LOCKED) ? owner_q : pick_sel;

  always_comb begin
    win_req   = bif.m0_req;
    win_lock  = bif.m0_lock;
    win_wen   = bif.m0_wen;
    win_addr  = bif.m0_addr;
    win_wdata = bif.m0_wdata;
    if (win_c == MID_M1) begin
      win_req   = bif.m1_req;
      win_lock  = bif.m1_lock;
      win_wen   = bif.m1_wen;
      win_addr  = bif.m1_addr;
      win_wdata = bif.m1_wdata;
    end
  end

  // In IDLE the picker only selects a requester, so win_req == pick_any there.
  assign en_c = ~areset & win_req & ((state_q == ARB_LOCKED) | pick_any);

  assign bif.m0_gnt    = en_c & (win_c == MID_M0);
  assign bif.m1_gnt    = en_c & (win_c == MID_M1);
  assign bif.bus_en    = en_c;
  assign bif.bus_wen   = en_c ? win_wen   : '0;
  assign bif.bus_addr  = en_c ? win_addr  : '0;
  assign bif.bus_wdata = en_c ? win_wdata : '0;

  assign bif.m0_rvalid = ~areset & rd_pend_q & (rd_id_q == MID_M0);
  assign bif.m1_rvalid = ~areset & rd_pend_q & (rd_id_q == MID_M1);
  assign bif.m0_rdata  = bif.bus_rdata;
  assign bif.m1_rdata  = bif.bus_rdata;

  assign arb_owner = owner_q;

`ifdef GPU_ARB_WDOG_EN
  localparam int unsigned CW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wdog_q, wdog_d;
  assign wdog_err = wdog_q;
`else
  assign wdog_err = 1'b0;
`endif

  // Next-state: lock entry/exit, round-robin history, read-return tracking.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rd_pend_d = en_c & (win_wen == '0);
    rd_id_d   = win_c;
`ifdef GPU_ARB_WDOG_EN
    cnt_d     = '0;
    wdog_d    = wdog_q;
`endif
    if (en_c) owner_d = win_c;
    case (state_q)
      ARB_IDLE:   if (en_c &  win_lock) state_d = ARB_LOCKED;
      ARB_LOCKED: if (en_c & ~win_lock) state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
`ifdef GPU_ARB_WDOG_EN
    if (state_q == ARB_LOCKED) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(LOCK_MAX - 1)) begin
        state_d = ARB_IDLE;
        wdog_d  = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= ARB_IDLE;
      owner_q   <= MID_M1;
      rd_pend_q <= 1'b0;
      rd_id_q   <= MID_M0;
`ifdef GPU_ARB_WDOG_EN
      cnt_q     <= '0;
      wdog_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
`ifdef GPU_ARB_WDOG_EN
      cnt_q     <= cnt_d;
      wdog_q    <= wdog_d;
`endif
    end
  end

endmodule

// File: tb/tb_gpu_bus_arbiter.sv
// Bench for gpu_bus_arbiter: directed scenarios then random traffic, all
// checked each cycle against a transaction-level model of the arbitration rules.
module tb_gpu_bus_arbiter;
  import gpu_bus_arbiter_pkg::*;

  localparam int unsigned AW = GPU_BUS_AW;
`ifdef GPU_ARB_WDOG_EN
  localparam int unsigned LM = 8;
`endif

  logic aclk   = 1'b0;
  logic areset = 1'b1;
  logic arb_owner, wdog_err;

  gpu_bus_arbiter_if #(.AW(AW)) bif ();

  gpu_bus_arbiter #(
    .AW(AW)
`ifdef GPU_ARB_WDOG_EN
    , .LOCK_MAX(LM)
`endif
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .bif       (bif),
    .arb_owner (arb_owner),
    .wdog_err  (wdog_err)
  );

  always #5 aclk = ~aclk;

  int checks   = 0;
  int failures = 0;

  // Per-master command currently presented (held until granted)
  logic          c_req [2];
  logic          c_lock[2];
  logic [3:0]    c_wen [2];
  logic [AW-1:0] c_addr[2];
  logic [31:0]   c_wdata[2];
  logic [31:0]   rdata_drv;

  // Reference model: who won last, lock holder, pending read owner
  int m_last, m_owner, m_lcnt, m_pend;
  bit m_locked, m_wdog;
  int obs_win;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    m_last = 1; m_owner = 0; m_lcnt = 0; m_pend = -1;
    m_locked = 1'b0; m_wdog = 1'b0;
  endtask

  task automatic set_cmd(input int i, input logic req, input logic lock, input logic [3:0] wen,
                         input logic [AW-1:0] addr, input logic [31:0] wdata);
    c_req[i] = req; c_lock[i] = lock; c_wen[i] = wen; c_addr[i] = addr; c_wdata[i] = wdata;
  endtask

  task automatic refresh(input int i);
    c_req[i]   = ($urandom_range(3) != 0);
    c_lock[i]  = ($urandom_range(3) == 0);
    c_wen[i]   = ($urandom_range(1) == 1) ? 4'($urandom_range(15)) : 4'h0;
    c_addr[i]  = AW'($urandom) & ~AW'(3);
    c_wdata[i] = $urandom;
  endtask

  // One clock: drive at negedge, check 1 time unit later, advance model, wait next negedge.
  task automatic cycle();
    int win;
    logic [3:0]    e_wen;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_wdata;
    rdata_drv = $urandom;
    bif.m0_req = c_req[0];  bif.m0_lock = c_lock[0]; bif.m0_wen = c_wen[0];
    bif.m0_addr = c_addr[0]; bif.m0_wdata = c_wdata[0];
    bif.m1_req = c_req[1];  bif.m1_lock = c_lock[1]; bif.m1_wen = c_wen[1];
    bif.m1_addr = c_addr[1]; bif.m1_wdata = c_wdata[1];
    bif.bus_rdata = rdata_drv;
    if (areset) mdl_reset();
    #1;
    win = -1;
    if (!areset) begin
      if (m_locked) begin
        if (c_req[m_owner]) win = m_owner;
      end else if (c_req[0] && c_req[1]) win = 1 - m_last;
      else if (c_req[0]) win = 0;
      else if (c_req[1]) win = 1;
    end
    e_wen = 4'h0; e_addr = '0; e_wdata = '0;
    if (win >= 0) begin
      e_wen = c_wen[win]; e_addr = c_addr[win]; e_wdata = c_wdata[win];
    end
    chk("m0_gnt",    bif.m0_gnt,    win == 0);
    chk("m1_gnt",    bif.m1_gnt,    win == 1);
    chk("bus_en",    bif.bus_en,    win >= 0);
    chk("bus_wen",   bif.bus_wen,   e_wen);
    chk("bus_addr",  bif.bus_addr,  e_addr);
    chk("bus_wdata", bif.bus_wdata, e_wdata);
    chk("m0_rvalid", bif.m0_rvalid, m_pend == 0);
    chk("m1_rvalid", bif.m1_rvalid, m_pend == 1);
    chk("m0_rdata",  bif.m0_rdata,  rdata_drv);
    chk("m1_rdata",  bif.m1_rdata,  rdata_drv);
    chk("arb_owner", arb_owner,     m_last == 1);
    chk("wdog_err",  wdog_err,      m_wdog);
    obs_win = bif.m1_gnt ? 1 : (bif.m0_gnt ? 0 : -1);
    if (!areset) begin
      m_pend = (win >= 0 && e_wen == 4'h0) ? win : -1;
      if (m_locked) begin
        if (win == m_owner && !c_lock[m_owner]) m_locked = 1'b0;
`ifdef GPU_ARB_WDOG_EN
        if (m_lcnt == LM - 1) begin
          m_locked = 1'b0;
          m_wdog   = 1'b1;
        end
        m_lcnt++;
`endif
      end else if (win >= 0 && c_lock[win]) begin
        m_locked = 1'b1; m_owner = win; m_lcnt = 0;
      end
      if (win >= 0) m_last = win;
    end
    @(negedge aclk);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    cycle();
    areset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) set_cmd(i, 1'b0, 1'b0, 4'h0, '0, '0);
    mdl_reset();
    obs_win = -1;
    @(negedge aclk);
    cycle();
    areset = 1'b0;

    // Single write from m0: granted in the same cycle, no read return
    set_cmd(0, 1'b1, 1'b0, 4'hF, AW'(32'h00010), 32'hA5A5A5A5);
    cycle();
    chk("t1_win", obs_win, 0);
    set_cmd(0, 1'b0, 1'b0, 4'h0, '0, '0);
    cycle();

    // Both masters read continuously: strict alternation starting at m0
    do_reset();
    set_cmd(0, 1'b1, 1'b0, 4'h0, AW'(32'h00100), 32'h0);
    set_cmd(1, 1'b1, 1'b0, 4'h0, AW'(32'h00200), 32'h0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t2_win", obs_win, k % 2);
    end
    set_cmd(0, 1'b0, 1'b0, 4'h0, '0, '0);
    set_cmd(1, 1'b0, 1'b0, 4'h0, '0, '0);
    cycle();

    // m1 three-beat locked burst while m0 waits
    set_cmd(1, 1'b1, 1'b1, 4'h0, AW'(32'h40000), 32'h0);
    cycle();
    chk("t3_win0", obs_win, 1);
    set_cmd(0, 1'b1, 1'b0, 4'hF, AW'(32'h00104), 32'h11111111);
    set_cmd(1, 1'b1, 1'b1, 4'hF, AW'(32'h40004), 32'h22222222);
    cycle();
    chk("t3_win1", obs_win, 1);
    set_cmd(1, 1'b1, 1'b0, 4'hF, AW'(32'h40008), 32'h33333333);
    cycle();
    chk("t3_win2", obs_win, 1);
    set_cmd(1, 1'b0, 1'b0, 4'h0, '0, '0);
    cycle();
    chk("t3_win3", obs_win, 0);
    set_cmd(0, 1'b0, 1'b0, 4'h0, '0, '0);

    // m1 lock with a 5-cycle gap: bus stays idle, m0 blocked
    set_cmd(1, 1'b1, 1'b1, 4'hF, AW'(32'h40010), 32'h44444444);
    cycle();
    chk("t4_lock", obs_win, 1);
    set_cmd(1, 1'b0, 1'b0, 4'h0, '0, '0);
    set_cmd(0, 1'b1, 1'b0, 4'hF, AW'(32'h00108), 32'h55555555);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t4_gap", obs_win, -1);
    end
    set_cmd(1, 1'b1, 1'b0, 4'hF, AW'(32'h40014), 32'h66666666);
    cycle();
    chk("t4_final", obs_win, 1);
    set_cmd(1, 1'b0, 1'b0, 4'h0, '0, '0);
    cycle();
    chk("t4_m0", obs_win, 0);
    set_cmd(0, 1'b0, 1'b0, 4'h0, '0, '0);

    // Reset during a lock with a read outstanding, then after an m0 read
    set_cmd(1, 1'b1, 1'b1, 4'hF, AW'(32'h40020), 32'h77777777);
    cycle();
    set_cmd(1, 1'b1, 1'b1, 4'h0, AW'(32'h40024), 32'h0);
    cycle();
    chk("t5_m1rd", obs_win, 1);
    set_cmd(0, 1'b1, 1'b0, 4'h0, AW'(32'h00300), 32'h0);
    set_cmd(1, 1'b0, 1'b0, 4'h0, '0, '0);
    do_reset();
    chk("t5_rst_gnt", obs_win, -1);
    cycle();
    chk("t5_m0rd", obs_win, 0);
    do_reset();
    set_cmd(1, 1'b1, 1'b0, 4'h0, AW'(32'h00400), 32'h0);
    cycle();
    chk("t5_tie", obs_win, 0);
    set_cmd(0, 1'b0, 1'b0, 4'h0, '0, '0);
    cycle();
    set_cmd(1, 1'b0, 1'b0, 4'h0, '0, '0);
    cycle();

`ifdef GPU_ARB_WDOG_EN
    // m0 never releases its lock: watchdog forces IDLE and m1 wins next
    do_reset();
    set_cmd(0, 1'b1, 1'b1, 4'hF, AW'(32'h00500), 32'h88888888);
    set_cmd(1, 1'b1, 1'b0, 4'hF, AW'(32'h00600), 32'h99999999);
    cycle();
    chk("t6_enter", obs_win, 0);
    for (int k = 0; k < int'(LM); k++) begin
      cycle();
      chk("t6_hold", obs_win, 0);
    end
    cycle();
    chk("t6_m1", obs_win, 1);
    chk("t6_wdog", wdog_err, 1'b1);
    set_cmd(0, 1'b0, 1'b0, 4'h0, '0, '0);
    set_cmd(1, 1'b0, 1'b0, 4'h0, '0, '0);
    cycle();
    chk("t6_sticky", wdog_err, 1'b1);
`endif

    // Random traffic with occasional resets
    do_reset();
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 2; i++)
        if (!c_req[i] || obs_win == i) refresh(i);
      areset = ($urandom_range(99) == 0);
      cycle();
    end
    areset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
